// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush that zeroes control fields, and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W      = 8,
    parameter int INSTR_W     = 19,
    parameter int CTRL_W      = 13,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_A,
    input  logic [DATA_W-1:0]      in_B,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_A,
    output logic [DATA_W-1:0]      out_B,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [INSTR_W-1:0] instr;
        logic [CTRL_W-1:0]  ctrl;
    } payload_t;

    state_t                   state_q, state_d;
    payload_t                 main_q, main_d;
    payload_t                 skid_q, skid_d;
    payload_t                 in_pl;
    logic                     in_ready_q, in_ready_d;
    logic [STALL_CNT_W-1:0]   stall_q, stall_d;
    logic                     in_fire;
    logic                     out_fire;

    assign in_pl     = '{a: in_A, b: in_B, instr: in_instr, ctrl: in_ctrl};
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}}))
            stall_d = stall_q + STALL_CNT_W'(1);

        if (flush) begin
            // Operand/instruction payload is left as-is; only control must be squashed.
            state_d     = EMPTY;
            main_d.ctrl = '0;
            skid_d.ctrl = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_pl;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_pl;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_pl;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Registered ready: drops one cycle late, the skid absorbs that extra beat.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_A     = main_q.a;
    assign out_B     = main_q.b;
    assign out_instr = main_q.instr;
    assign out_ctrl  = out_valid ? main_q.ctrl : '0;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid: reset, streaming, back-pressure,
// flush, simultaneous transfer and stall counter saturation (second instance, 4-bit counter).
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [7:0]  in_A, in_B;
    logic [18:0] in_instr;
    logic [12:0] in_ctrl;

    logic        in_ready, out_valid;
    logic [7:0]  out_A, out_B;
    logic [18:0] out_instr;
    logic [12:0] out_ctrl;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_A, s_out_B;
    logic [18:0] s_out_instr;
    logic [12:0] s_out_ctrl;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
        .out_instr(out_instr), .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_A(in_A), .in_B(in_B), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_A(s_out_A), .out_B(s_out_B),
        .out_instr(s_out_instr), .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    always @(posedge clk) begin
        if (reset && out_valid && out_ready)
            $display("[%0t] out transfer A=%h B=%h instr=%h ctrl=%h", $time, out_A, out_B, out_instr, out_ctrl);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_A = 8'h55; in_B = 8'h66; in_instr = 19'h12345; in_ctrl = 13'h1ABC;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL reset_out_ctrl[%0d]: got %h want 0", i, out_ctrl); end
            checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall[%0d]: got %0d want 0", i, stall_cnt); end
        end
        reset = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL release_occupancy: got %0d want 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_nothing_accepted: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_ctrl = 13'h1FFF;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_A = 8'(i); in_B = 8'(8'hF0 ^ i); in_instr = 19'(i * 3);
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_A !== 8'(i)) begin errors++; $display("FAIL stream_A[%0d]: got %h want %h", i, out_A, 8'(i)); end
            checks++; if (out_B !== 8'(8'hF0 ^ i)) begin errors++; $display("FAIL stream_B[%0d]: got %h want %h", i, out_B, 8'(8'hF0 ^ i)); end
            checks++; if (out_instr !== 19'(i * 3)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, 19'(i * 3)); end
            checks++; if (out_ctrl !== 13'h1FFF) begin errors++; $display("FAIL stream_ctrl[%0d]: got %h want 1fff", i, out_ctrl); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
        checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL stream_drain_ctrl: got %h want 0", out_ctrl); end
        checks++; if (out_A !== 8'h10) begin errors++; $display("FAIL stream_drain_hold_A: got %h want 10", out_A); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d want 0", occupancy); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0; in_ctrl = 13'h0A5A;
        in_valid = 1'b1; in_A = 8'hA1;
        tick();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1: got %0d want 1", occupancy); end
        checks++; if (out_A !== 8'hA1) begin errors++; $display("FAIL bp_head1: got %h want a1", out_A); end
        in_A = 8'hA2;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2: got %0d want 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL bp_stall1: got %0d want 1", stall_cnt); end
        in_A = 8'hA3;
        tick();
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_hold: got %0d want 2", occupancy); end
        checks++; if (out_A !== 8'hA1) begin errors++; $display("FAIL bp_head_hold: got %h want a1", out_A); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall3: got %0d want 3", stall_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_A !== 8'hA2) begin errors++; $display("FAIL bp_drain_A2: got %h want a2", out_A); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_drain_occ: got %0d want 1", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_A !== 8'hA3) begin errors++; $display("FAIL bp_drain_A3: got %h want a3", out_A); end
        checks++; if (out_ctrl !== 13'h0A5A) begin errors++; $display("FAIL bp_ctrl: got %h want 0a5a", out_ctrl); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_final: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_flush_two();
        out_ready = 1'b0; in_ctrl = 13'h0123;
        in_valid = 1'b1; in_A = 8'hB1;
        tick();
        in_A = 8'hB2;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
        flush = 1'b1; in_valid = 1'b1; in_A = 8'hEE; in_ctrl = 13'h1EEE;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (out_ctrl !== 13'h0) begin errors++; $display("FAIL flush_ctrl: got %h want 0", out_ctrl); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL flush_stall: got %0d want 5", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_EE_valid: got %b want 0", out_valid); end
        checks++; if (out_A !== 8'hB1) begin errors++; $display("FAIL flush_hold_A: got %h want b1", out_A); end
        in_valid = 1'b1; in_A = 8'hC1; in_ctrl = 13'h0C1C;
        tick();
        checks++; if (out_A !== 8'hC1 || out_ctrl !== 13'h0C1C) begin errors++; $display("FAIL flush_after_accept: got A=%h ctrl=%h want A=c1 ctrl=0c1c", out_A, out_ctrl); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_ctrl = 13'h0777;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_A = 8'(8'h30 + i);
            tick();
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL b2b_occ[%0d]: got %0d want 1", i, occupancy); end
            checks++; if (out_A !== 8'(8'h30 + i)) begin errors++; $display("FAIL b2b_A[%0d]: got %h want %h", i, out_A, 8'(8'h30 + i)); end
        end
        flush = 1'b1; in_A = 8'h77;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_flush_valid: got %b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL b2b_flush_occ: got %0d want 0", occupancy); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_flush: got %b want 0", out_valid); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL b2b_stall: got %0d want 5", stall_cnt); end
    endtask

    task automatic test_saturation();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (s_stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_reset: got %0d want 0", s_stall_cnt); end
        in_valid = 1'b1; in_A = 8'hD1; in_ctrl = 13'h0001;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (s_stall_cnt !== 4'((k > 15) ? 15 : k)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, s_stall_cnt, (k > 15) ? 15 : k); end
            checks++; if (stall_cnt !== 16'(k)) begin errors++; $display("FAIL wide_cnt[%0d]: got %0d want %0d", k, stall_cnt, k); end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_after_flush: got %0d want 15", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd21) begin errors++; $display("FAIL wide_after_flush: got %0d want 21", stall_cnt); end
        tick();
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", s_stall_cnt); end
        reset = 1'b0;
        tick();
        checks++; if (s_stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_cleared: got %0d want 0", s_stall_cnt); end
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_two();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
